// File: rtl/montgomery_pkg.sv
// Shared definitions for the Montgomery exponentiation controller, multiplier and wrappers.
package montgomery_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_EXP_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ,
    S_WAIT_SQ,
    S_MUL,
    S_WAIT_MUL,
    S_CONV,
    S_WAIT_CONV,
    S_DONE
  } state_t;

endpackage

// File: rtl/montgomery_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// The final multiply by 1 converts the accumulator out of the Montgomery domain.
module montgomery_exp_ctrl
  import montgomery_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned EXP_W = DEFAULT_EXP_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base_m,
  input  logic [WIDTH-1:0] one_m,
  input  logic [EXP_W-1:0] exponent,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_result
);

  localparam int unsigned IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   x;
  logic [EXP_W-1:0]   e;
  logic [IDX_W-1:0]   idx;
  logic               last_bit;

  assign last_bit = (idx == '0);

  // Controller state, datapath registers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
      acc      <= '0;
      x        <= '0;
      e        <= '0;
      idx      <= '0;
    end else begin
      mm_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            x     <= base_m;
            acc   <= one_m;
            e     <= exponent;
            idx   <= IDX_W'(EXP_W - 1);
            busy  <= 1'b1;
            state <= S_SQ;
          end
        end
        S_SQ: begin
          mm_start <= 1'b1;
          mm_a     <= acc;
          mm_b     <= acc;
          state    <= S_WAIT_SQ;
        end
        S_WAIT_SQ: begin
          if (mm_done) begin
            acc <= mm_result;
            if (e[idx]) begin
              state <= S_MUL;
            end else if (last_bit) begin
              state <= S_CONV;
            end else begin
              idx   <= idx - IDX_W'(1);
              state <= S_SQ;
            end
          end
        end
        S_MUL: begin
          mm_start <= 1'b1;
          mm_a     <= acc;
          mm_b     <= x;
          state    <= S_WAIT_MUL;
        end
        S_WAIT_MUL: begin
          if (mm_done) begin
            acc <= mm_result;
            if (last_bit) begin
              state <= S_CONV;
            end else begin
              idx   <= idx - IDX_W'(1);
              state <= S_SQ;
            end
          end
        end
        S_CONV: begin
          mm_start <= 1'b1;
          mm_a     <= acc;
          mm_b     <= WIDTH'(1);
          state    <= S_WAIT_CONV;
        end
        S_WAIT_CONV: begin
          if (mm_done) begin
            result <= mm_result;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_exp_ctrl.sv
// Scoreboard bench for montgomery_exp_ctrl with a behavioural mod-13 Montgomery multiplier.
module tb_montgomery_exp_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned EXP_W = 8;
  localparam int MOD_N = 13;
  localparam int ONE_M = 9;   // 256 mod 13
  localparam int R_INV = 3;   // 9 * 3 = 27 = 1 mod 13

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] base_m;
  logic [WIDTH-1:0] one_m;
  logic [EXP_W-1:0] exponent;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             mm_start;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic             mm_done;
  logic [WIDTH-1:0] mm_result;

  logic             mult_done;
  logic [WIDTH-1:0] mult_res;
  logic             inj_done;
  logic [WIDTH-1:0] inj_res;

  assign mm_done   = mult_done | inj_done;
  assign mm_result = inj_done ? inj_res : mult_res;

  montgomery_exp_ctrl #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
    .clock(clock), .reset(reset), .start(start), .base_m(base_m), .one_m(one_m),
    .exponent(exponent), .busy(busy), .done(done), .result(result),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_done(mm_done), .mm_result(mm_result)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int res;
    int nmul;
  } exp_t;

  exp_t sb[$];

  // b^e mod N by repeated multiplication, with b recovered from its Montgomery form.
  function automatic int ref_exp(input int bm, input int e);
    int b, r;
    b = (bm * R_INV) % MOD_N;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % MOD_N;
    return r;
  endfunction

  // Behavioural multiplier: a*b*R^-1 mod N after 'lat' cycles.
  int lat = 1;
  bit pend = 0;
  int remain, cap_a, cap_b;
  bit stable;
  initial begin
    mult_done = 1'b0;
    mult_res  = '0;
    forever begin
      @(negedge clock);
      mult_done = 1'b0;
      if (reset) begin
        pend = 0;
      end else begin
        if (pend) begin
          if (int'(mm_a) != cap_a || int'(mm_b) != cap_b) stable = 0;
          remain--;
          if (remain == 0) begin
            check("operand_hold", int'(stable), 1);
            mult_done = 1'b1;
            mult_res  = 8'((cap_a * cap_b * R_INV) % MOD_N);
            pend = 0;
          end
        end
        if (mm_start) begin
          check("mm_start_while_pending", int'(pend), 0);
          pend   = 1;
          remain = lat;
          cap_a  = int'(mm_a);
          cap_b  = int'(mm_b);
          stable = 1;
        end
      end
    end
  end

  // Monitor: counts multiplies per job and checks each done against the scoreboard.
  int mcount = 0;
  int done_cnt = 0;
  bit prev_done = 0;
  initial begin
    exp_t ex;
    forever begin
      @(negedge clock);
      if (reset) begin
        mcount = 0;
        prev_done = 0;
      end else begin
        if (mm_start) mcount++;
        if (done) begin
          done_cnt++;
          check("done_single_cycle", int'(prev_done), 0);
          check("busy_low_at_done", int'(busy), 0);
          check("done_has_expectation", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            ex = sb.pop_front();
            check("result", int'(result), ex.res);
            check("multiply_count", mcount, ex.nmul);
          end
          mcount = 0;
        end
        prev_done = done;
      end
    end
  end

  task automatic issue(input int bm, input int e, input int l);
    logic [EXP_W-1:0] ev;
    exp_t ex;
    ev = 8'(e);
    @(negedge clock);
    lat      = l;
    base_m   = 8'(bm);
    exponent = ev;
    start    = 1'b1;
    ex.res   = ref_exp(bm, e);
    ex.nmul  = int'(EXP_W) + $countones(ev) + 1;
    sb.push_back(ex);
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(input int budget);
    int c0, n;
    c0 = done_cnt;
    n  = 0;
    while (done_cnt == c0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("job_completes_in_budget", int'(done_cnt != c0), 1);
  endtask

  initial begin
    int dc, n, nstart, last_exp, bm, e;
    reset    = 1'b1;
    start    = 1'b0;
    base_m   = '0;
    one_m    = 8'(ONE_M);
    exponent = '0;
    inj_done = 1'b0;
    inj_res  = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_mm_start", int'(mm_start), 0);
    check("reset_result", int'(result), 0);
    check("reset_mm_a", int'(mm_a), 0);
    check("reset_mm_b", int'(mm_b), 0);
    reset = 1'b0;

    // Directed jobs: basic, zero exponent, all-ones exponent on a slow multiplier.
    issue(5, 5, 1);     wait_done(300);
    issue(5, 0, 1);     wait_done(300);
    issue(5, 255, 20);  wait_done(3000);

    // Start pulses while busy are ignored.
    issue(7, 8'hA5, 3);
    repeat (10) @(negedge clock);
    base_m = 8'd3; exponent = 8'h0F; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(1000);
    dc = done_cnt;
    repeat (60) @(negedge clock);
    check("no_extra_done_after_busy_start", done_cnt, dc);
    issue(3, 8'h0F, 2); wait_done(1000);

    // Reset while the first MUL is in flight (e=0x80: pulse 1 is SQ, pulse 2 is MUL).
    issue(6, 8'h80, 10);
    nstart = 0;
    n = 0;
    while (nstart < 2 && n < 200) begin
      @(negedge clock);
      n++;
      if (mm_start) nstart++;
    end
    check("reached_wait_mul", nstart, 2);
    #2 reset = 1'b1;
    #1;
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_mm_start", int'(mm_start), 0);
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    dc = done_cnt;
    @(negedge clock);
    inj_done = 1'b1; inj_res = 8'd4;
    @(negedge clock);
    inj_done = 1'b0;
    repeat (30) @(negedge clock);
    check("late_mm_done_no_done", done_cnt, dc);
    check("late_mm_done_busy", int'(busy), 0);
    check("late_mm_done_result", int'(result), 0);
    issue(6, 8'h80, 10); wait_done(1000);

    // Randomized jobs.
    last_exp = 0;
    for (int j = 0; j < 8; j++) begin
      bm = int'($urandom_range(0, 12));
      e  = int'($urandom_range(0, 255));
      last_exp = ref_exp(bm, e);
      issue(bm, e, int'($urandom_range(1, 6)));
      wait_done(2000);
    end

    // Spurious mm_done while idle.
    dc = done_cnt;
    @(negedge clock);
    inj_done = 1'b1; inj_res = 8'(last_exp + 1);
    @(negedge clock);
    inj_done = 1'b0;
    repeat (20) @(negedge clock);
    check("spurious_mm_done_result", int'(result), last_exp);
    check("spurious_mm_done_no_done", done_cnt, dc);
    check("spurious_mm_done_busy", int'(busy), 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
